// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone classic master: turns one command into one bus
// transaction with retry/backoff and a stall timeout, then returns a response.
module wb_cmd_master #(
   parameter int AW        = 32,
   parameter int DW        = 8,
   parameter int TIMEOUT   = 255,
   parameter int MAX_RETRY = 3
) (
   input  logic          wb_clk,
   input  logic          wb_rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_we,
   input  logic [AW-1:0] cmd_adr,
   input  logic [DW-1:0] cmd_dat,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_dat,
   output logic [1:0]    rsp_status,
   output logic [AW-1:0] wb_adr_o,
   output logic [DW-1:0] wb_dat_o,
   output logic          wb_we_o,
   output logic          wb_cyc_o,
   output logic          wb_stb_o,
   output logic [2:0]    wb_cti_o,
   output logic [1:0]    wb_bte_o,
   input  logic [DW-1:0] wb_dat_i,
   input  logic          wb_ack_i,
   input  logic          wb_err_i,
   input  logic          wb_rty_i,
   output logic          busy
);

   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [TW-1:0] TMO_LIMIT   = TW'(TIMEOUT);
   localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

   localparam logic [1:0] ST_OK  = 2'b00;
   localparam logic [1:0] ST_ERR = 2'b01;
   localparam logic [1:0] ST_TMO = 2'b10;
   localparam logic [1:0] ST_RTY = 2'b11;

   typedef enum logic [1:0] {IDLE, BUS, BACKOFF, RESP} state_t;

   state_t        state, state_nxt;
   logic          cmd_ready_nxt;
   logic [AW-1:0] adr_nxt;
   logic [DW-1:0] dat_nxt;
   logic          we_nxt, cyc_nxt, stb_nxt;
   logic          rsp_valid_nxt;
   logic [DW-1:0] rsp_dat_nxt;
   logic [1:0]    rsp_status_nxt;
   logic [RW-1:0] retry_cnt, retry_nxt;
   logic [TW-1:0] tmo_cnt, tmo_nxt, tmo_inc;

   assign wb_cti_o = 3'b000;
   assign wb_bte_o = 2'b00;
   assign busy     = (state != IDLE);
   assign tmo_inc  = tmo_cnt + 1'b1;

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state      <= IDLE;
         cmd_ready  <= 1'b0;
         wb_adr_o   <= '0;
         wb_dat_o   <= '0;
         wb_we_o    <= 1'b0;
         wb_cyc_o   <= 1'b0;
         wb_stb_o   <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_dat    <= '0;
         rsp_status <= ST_OK;
         retry_cnt  <= '0;
         tmo_cnt    <= '0;
      end else begin
         state      <= state_nxt;
         cmd_ready  <= cmd_ready_nxt;
         wb_adr_o   <= adr_nxt;
         wb_dat_o   <= dat_nxt;
         wb_we_o    <= we_nxt;
         wb_cyc_o   <= cyc_nxt;
         wb_stb_o   <= stb_nxt;
         rsp_valid  <= rsp_valid_nxt;
         rsp_dat    <= rsp_dat_nxt;
         rsp_status <= rsp_status_nxt;
         retry_cnt  <= retry_nxt;
         tmo_cnt    <= tmo_nxt;
      end
   end

   // Every output is computed one cycle ahead so the bus side sees only flops.
   always_comb begin
      state_nxt      = state;
      adr_nxt        = wb_adr_o;
      dat_nxt        = wb_dat_o;
      we_nxt         = wb_we_o;
      cyc_nxt        = wb_cyc_o;
      stb_nxt        = wb_stb_o;
      rsp_valid_nxt  = rsp_valid;
      rsp_dat_nxt    = rsp_dat;
      rsp_status_nxt = rsp_status;
      retry_nxt      = retry_cnt;
      tmo_nxt        = tmo_cnt;
      cmd_ready_nxt  = 1'b0;

      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               adr_nxt   = cmd_adr;
               dat_nxt   = cmd_dat;
               we_nxt    = cmd_we;
               cyc_nxt   = 1'b1;
               stb_nxt   = 1'b1;
               retry_nxt = '0;
               tmo_nxt   = '0;
               state_nxt = BUS;
            end
         end
         BUS: begin
            if (wb_stb_o) begin
               if (wb_ack_i) begin
                  rsp_dat_nxt    = wb_we_o ? '0 : wb_dat_i;
                  rsp_status_nxt = ST_OK;
                  rsp_valid_nxt  = 1'b1;
                  cyc_nxt        = 1'b0;
                  stb_nxt        = 1'b0;
                  state_nxt      = RESP;
               end else if (wb_err_i) begin
                  rsp_dat_nxt    = '0;
                  rsp_status_nxt = ST_ERR;
                  rsp_valid_nxt  = 1'b1;
                  cyc_nxt        = 1'b0;
                  stb_nxt        = 1'b0;
                  state_nxt      = RESP;
               end else if (wb_rty_i) begin
                  cyc_nxt = 1'b0;
                  stb_nxt = 1'b0;
                  if (retry_cnt < RETRY_LIMIT) begin
                     retry_nxt = retry_cnt + 1'b1;
                     state_nxt = BACKOFF;
                  end else begin
                     rsp_dat_nxt    = '0;
                     rsp_status_nxt = ST_RTY;
                     rsp_valid_nxt  = 1'b1;
                     state_nxt      = RESP;
                  end
               end else if (tmo_inc == TMO_LIMIT) begin
                  rsp_dat_nxt    = '0;
                  rsp_status_nxt = ST_TMO;
                  rsp_valid_nxt  = 1'b1;
                  cyc_nxt        = 1'b0;
                  stb_nxt        = 1'b0;
                  state_nxt      = RESP;
               end else begin
                  tmo_nxt = tmo_inc;
               end
            end
         end
         BACKOFF: begin
            cyc_nxt   = 1'b1;
            stb_nxt   = 1'b1;
            tmo_nxt   = '0;
            state_nxt = BUS;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_nxt = 1'b0;
               state_nxt     = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Ready is registered, so it follows the state we are about to enter.
      cmd_ready_nxt = (state_nxt == IDLE);
   end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with a small behavioural Wishbone slave
// whose termination behaviour is selected per step.
module tb_wb_cmd_master;

   localparam int AW = 32;
   localparam int DW = 8;

   logic          wb_clk, wb_rst_n;
   logic          cmd_valid, cmd_ready, cmd_we;
   logic [AW-1:0] cmd_adr;
   logic [DW-1:0] cmd_dat;
   logic          rsp_valid, rsp_ready;
   logic [DW-1:0] rsp_dat;
   logic [1:0]    rsp_status;
   logic [AW-1:0] wb_adr_o;
   logic [DW-1:0] wb_dat_o;
   logic          wb_we_o, wb_cyc_o, wb_stb_o;
   logic [2:0]    wb_cti_o;
   logic [1:0]    wb_bte_o;
   logic [DW-1:0] wb_dat_i;
   logic          wb_ack_i, wb_err_i, wb_rty_i;
   logic          busy;

   wb_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT(8), .MAX_RETRY(3)) dut (
      .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
      .rsp_status(rsp_status),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o),
      .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
      .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .busy(busy)
   );

   initial begin
      wb_clk = 1'b0;
      forever #5 wb_clk = ~wb_clk;
   end

   // Slave modes: 0 ack after ackDelay, 1 err, 2 rty for rtyCount attempts
   // then ack, 3 silent, 4 ack+err+rty together.
   int   mode = 3;
   int   ackDelay = 0;
   int   rtyCount = 0;
   int   base = 0;
   int   waitCnt = 0;
   int   pulseCnt = 0;
   int   stbHigh = 0;
   int   attempt;
   logic stbQ = 1'b0;

   always @(posedge wb_clk) begin
      stbQ    <= wb_stb_o;
      waitCnt <= wb_stb_o ? waitCnt + 1 : 0;
      if (wb_stb_o && !stbQ) pulseCnt <= pulseCnt + 1;
      if (wb_stb_o) stbHigh <= stbHigh + 1;
   end

   always_comb begin
      attempt  = pulseCnt - base + ((wb_stb_o && !stbQ) ? 1 : 0);
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_rty_i = 1'b0;
      if (wb_stb_o) begin
         case (mode)
            0: wb_ack_i = (waitCnt == ackDelay);
            1: wb_err_i = 1'b1;
            2: begin
               wb_rty_i = (attempt <= rtyCount);
               wb_ack_i = (attempt > rtyCount);
            end
            4: begin
               wb_ack_i = 1'b1;
               wb_err_i = 1'b1;
               wb_rty_i = 1'b1;
            end
            default: ;
         endcase
      end
   end

   int checks = 0;
   int passed = 0;
   int stbBase;

   task automatic tick();
      @(posedge wb_clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) passed++;
      else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
   endtask

   // Offers one command and returns just after the accepting edge.
   task automatic applyStimulus(input logic we, input logic [AW-1:0] adr,
                                input logic [DW-1:0] dat);
      base      = pulseCnt;
      stbBase   = stbHigh;
      cmd_we    = we;
      cmd_adr   = adr;
      cmd_dat   = dat;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic consumeResponse(input string tag);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checkOutput({tag, "_rsp_valid_drop"}, rsp_valid, 0);
      checkOutput({tag, "_cmd_ready_back"}, cmd_ready, 1);
   endtask

   initial begin
      wb_rst_n  = 1'b0;
      cmd_valid = 1'b0;
      cmd_we    = 1'b0;
      cmd_adr   = '0;
      cmd_dat   = '0;
      rsp_ready = 1'b0;
      wb_dat_i  = 8'hA5;

      tick();
      tick();
      checkOutput("rst_cmd_ready", cmd_ready, 0);
      checkOutput("rst_cyc", wb_cyc_o, 0);
      checkOutput("rst_stb", wb_stb_o, 0);
      checkOutput("rst_rsp_valid", rsp_valid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_adr", wb_adr_o, 0);
      checkOutput("rst_status", rsp_status, 0);
      wb_rst_n = 1'b1;
      checkOutput("rel_cmd_ready_before_edge", cmd_ready, 0);
      tick();
      checkOutput("rel_cmd_ready_after_edge", cmd_ready, 1);
      checkOutput("cti_const", wb_cti_o, 0);
      checkOutput("bte_const", wb_bte_o, 0);

      // Zero-wait write.
      mode = 0; ackDelay = 0;
      applyStimulus(1'b1, 32'h04, 8'hFF);
      checkOutput("wr_stb", wb_stb_o, 1);
      checkOutput("wr_we", wb_we_o, 1);
      checkOutput("wr_adr", wb_adr_o, 32'h04);
      checkOutput("wr_dat", wb_dat_o, 8'hFF);
      checkOutput("wr_cmd_ready_low", cmd_ready, 0);
      checkOutput("wr_busy", busy, 1);
      checkOutput("wr_rsp_not_yet", rsp_valid, 0);
      tick();
      checkOutput("wr_stb_drop", wb_stb_o, 0);
      checkOutput("wr_rsp_valid", rsp_valid, 1);
      checkOutput("wr_status", rsp_status, 2'b00);
      checkOutput("wr_rsp_dat", rsp_dat, 8'h00);
      checkOutput("wr_stb_width", stbHigh - stbBase, 1);
      consumeResponse("wr");

      // Read with three wait states.
      mode = 0; ackDelay = 3;
      applyStimulus(1'b0, 32'h00, 8'h11);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("rd_stb_%0d", i), wb_stb_o, 1);
         checkOutput($sformatf("rd_adr_%0d", i), wb_adr_o, 32'h00);
         tick();
      end
      checkOutput("rd_rsp_valid", rsp_valid, 1);
      checkOutput("rd_rsp_dat", rsp_dat, 8'hA5);
      checkOutput("rd_status", rsp_status, 2'b00);
      checkOutput("rd_stb_width", stbHigh - stbBase, 4);
      consumeResponse("rd");

      // Error on first strobe cycle.
      mode = 1;
      applyStimulus(1'b0, 32'h0C, 8'h00);
      checkOutput("err_stb", wb_stb_o, 1);
      tick();
      checkOutput("err_cyc_drop", wb_cyc_o, 0);
      checkOutput("err_rsp_valid", rsp_valid, 1);
      checkOutput("err_status", rsp_status, 2'b01);
      checkOutput("err_rsp_dat", rsp_dat, 8'h00);
      consumeResponse("err");

      // Two retries then ack: strobe pattern H L H L H.
      mode = 2; rtyCount = 2;
      applyStimulus(1'b1, 32'h08, 8'h3C);
      for (int i = 0; i < 2; i++) begin
         checkOutput($sformatf("rty_stb_hi_%0d", i), wb_stb_o, 1);
         tick();
         checkOutput($sformatf("rty_stb_lo_%0d", i), wb_stb_o, 0);
         checkOutput($sformatf("rty_busy_%0d", i), busy, 1);
         checkOutput($sformatf("rty_adr_hold_%0d", i), wb_adr_o, 32'h08);
         tick();
      end
      checkOutput("rty_stb_hi_last", wb_stb_o, 1);
      tick();
      checkOutput("rty_rsp_valid", rsp_valid, 1);
      checkOutput("rty_status", rsp_status, 2'b00);
      checkOutput("rty_pulses", pulseCnt - base, 3);
      consumeResponse("rty");

      // Retry on every attempt: four strobes then status 11.
      mode = 2; rtyCount = 4;
      applyStimulus(1'b0, 32'h10, 8'h00);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("rtx_stb_hi_%0d", i), wb_stb_o, 1);
         tick();
         checkOutput($sformatf("rtx_stb_lo_%0d", i), wb_stb_o, 0);
         tick();
      end
      checkOutput("rtx_stb_hi_last", wb_stb_o, 1);
      tick();
      checkOutput("rtx_rsp_valid", rsp_valid, 1);
      checkOutput("rtx_status", rsp_status, 2'b11);
      checkOutput("rtx_rsp_dat", rsp_dat, 8'h00);
      checkOutput("rtx_pulses", pulseCnt - base, 4);
      consumeResponse("rtx");

      // Silent slave: timeout after eight strobe cycles, then a stalled consumer.
      mode = 3;
      applyStimulus(1'b0, 32'h14, 8'h00);
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("tmo_stb_%0d", i), wb_stb_o, 1);
         tick();
      end
      checkOutput("tmo_stb_drop", wb_stb_o, 0);
      checkOutput("tmo_rsp_valid", rsp_valid, 1);
      checkOutput("tmo_status", rsp_status, 2'b10);
      checkOutput("tmo_rsp_dat", rsp_dat, 8'h00);
      cmd_valid = 1'b1; cmd_adr = 32'h55; cmd_we = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput($sformatf("hold_valid_%0d", i), rsp_valid, 1);
         checkOutput($sformatf("hold_status_%0d", i), rsp_status, 2'b10);
         checkOutput($sformatf("hold_dat_%0d", i), rsp_dat, 8'h00);
         checkOutput($sformatf("hold_cmd_ready_%0d", i), cmd_ready, 0);
      end
      checkOutput("hold_adr_kept", wb_adr_o, 32'h14);
      cmd_valid = 1'b0;
      consumeResponse("tmo");

      // Ack on the eighth strobe cycle beats the timeout.
      mode = 0; ackDelay = 7; wb_dat_i = 8'h5A;
      applyStimulus(1'b0, 32'h20, 8'h00);
      for (int i = 0; i < 8; i++) tick();
      checkOutput("edge_rsp_valid", rsp_valid, 1);
      checkOutput("edge_status", rsp_status, 2'b00);
      checkOutput("edge_rsp_dat", rsp_dat, 8'h5A);
      consumeResponse("edge");

      // All terminations at once: ack has priority.
      mode = 4; wb_dat_i = 8'hC3;
      applyStimulus(1'b0, 32'h24, 8'h00);
      tick();
      checkOutput("prio_rsp_valid", rsp_valid, 1);
      checkOutput("prio_status", rsp_status, 2'b00);
      checkOutput("prio_rsp_dat", rsp_dat, 8'hC3);
      consumeResponse("prio");

      // Reset in the middle of a bus cycle.
      mode = 3;
      applyStimulus(1'b0, 32'h18, 8'h00);
      tick();
      checkOutput("mid_stb_before_rst", wb_stb_o, 1);
      #2 wb_rst_n = 1'b0;
      #1;
      checkOutput("mid_cyc_async", wb_cyc_o, 0);
      checkOutput("mid_stb_async", wb_stb_o, 0);
      checkOutput("mid_rsp_valid_async", rsp_valid, 0);
      checkOutput("mid_busy_async", busy, 0);
      checkOutput("mid_adr_async", wb_adr_o, 0);
      tick();
      wb_rst_n = 1'b1;
      checkOutput("mid_cmd_ready_before_edge", cmd_ready, 0);
      tick();
      checkOutput("mid_cmd_ready_after_edge", cmd_ready, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput($sformatf("mid_no_rsp_%0d", i), rsp_valid, 0);
         checkOutput($sformatf("mid_no_stb_%0d", i), wb_stb_o, 0);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
